mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_MAX, default 3, range 1..15: consecutive denied cycles before port 1 is forced to win (used only with MEM_ARB_STARVE_LIMIT_EN).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_async  input  1  asynchronous, active-high reset.
REQ-004 p0_req  input  1  port 0 (CPU) transaction request, held until granted.
REQ-005 p0_addr  input  20  port 0 word address.
REQ-006 p0_we  input  1  port 0 write (1) / read (0).
REQ-007 p0_wdata  input  32  port 0 write data.
REQ-008 p0_gnt  output  1  port 0 grant; transaction completes at the posedge where it is high.
REQ-009 p0_rvalid  output  1  port 0 read data valid, one-cycle pulse.
REQ-010 p0_rdata  output  32  port 0 read data.
REQ-011 p1_req / p1_addr / p1_we / p1_wdata / p1_gnt / p1_rvalid / p1_rdata: same directions, widths and meanings as REQ-004..REQ-010, for port 1 (loader/debug).
REQ-012 mem_address  output  20  shared memory word address.
REQ-013 mem_write_en  output  1  shared memory write strobe.
REQ-014 mem_write_value  output  32  shared memory write data.
REQ-015 mem_read_value  input  32  shared memory read data, combinational from mem_address.

Function
REQ-016 pN_gnt SHALL be combinational from pN_req and registered arbiter state; at most one of p0_gnt, p1_gnt high per cycle.
REQ-017 No grant: mem_address, mem_write_en, mem_write_value SHALL all be 0.
REQ-018 Grant to port N: mem_address = pN_addr, mem_write_en = pN_we, mem_write_value = pN_wdata, same cycle.
REQ-019 Granted read: mem_read_value SHALL be captured into pN_rdata at that posedge; pN_rvalid high exactly the following cycle (latency 1).
REQ-020 Granted write: no rvalid pulse; pN_rdata unchanged.
REQ-021 pN_rdata SHALL hold its value until the next completed read on that port.
REQ-022 Back-to-back grants to one port SHALL be accepted every cycle (throughput 1 per cycle).
REQ-023 Priority: only one requesting -> that port granted; both requesting -> port 0 wins unless REQ-027 applies.
REQ-024 Requester dropping pN_req before grant SHALL cause no memory access and no rvalid.
REQ-025 Both ports targeting the same address SHALL be serialized; the loser sees the winner's write if granted later.

Reset
REQ-026 rst_async high SHALL immediately force p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write_en to 0, p0_rdata, p1_rdata, wait counter to 0; a read granted in the cycle before reset SHALL deliver no rvalid after reset release.

Configuration
REQ-027 MEM_ARB_STARVE_LIMIT_EN defined: 4-bit wait_cnt increments each cycle p1_req && !p1_gnt, clears on p1_gnt or !p1_req, saturates at WAIT_MAX; when wait_cnt == WAIT_MAX port 1 SHALL win over port 0.
REQ-028 MEM_ARB_STARVE_LIMIT_EN undefined: no wait counter; fixed priority, port 0 always wins, port 1 may starve indefinitely.

Verification
REQ-029 mem[9]=1, p0 read addr 0x00009 -> p0_gnt same cycle, next cycle p0_rvalid=1, p0_rdata=0x00000001.
REQ-030 p1 write addr 0x000ff data 0x12345678 -> mem_write_en=1 one cycle, mem_address=0x000ff; subsequent p0 read of 0x000ff returns 0x12345678.
REQ-031 Macro off, p0_req and p1_req held 20 cycles -> p0_gnt every cycle, p1_gnt never.
REQ-032 Macro on, WAIT_MAX=3, both held continuously -> grant pattern p0,p0,p0,p1 repeating; wait_cnt returns to 0 after each p1 grant.
REQ-033 p0 read then p0 write back-to-back -> one p0_rvalid pulse (cycle after read only); p0_rdata held through the write.
REQ-034 rst_async asserted the cycle after a p1 read grant -> p1_rvalid stays 0, p1_rdata=0, all grants 0 during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported word memory: port 0 (CPU) has fixed priority over port 1 (loader/debug).
// Define MEM_ARB_STARVE_LIMIT_EN to force a port 1 win after WAIT_MAX consecutive denied cycles.
module mem_arbiter #(
  parameter int WAIT_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_async,

  input  logic        p0_req,
  input  logic [19:0] p0_addr,
  input  logic        p0_we,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic [19:0] p1_addr,
  input  logic        p1_we,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,

  output logic [19:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_value,
  input  logic [31:0] mem_read_value
);

  localparam int NP = 2;

  if (WAIT_MAX < 1 || WAIT_MAX > 15) begin : g_bad_wait_max
    $error("mem_arbiter: WAIT_MAX must be in 1..15");
  end

  logic [NP-1:0] req;
  logic [NP-1:0] we;
  logic [NP-1:0] gnt;
  logic [19:0]   addr      [NP];
  logic [31:0]   wdata     [NP];
  logic [31:0]   rdata_reg [NP];
  logic          rvalid_reg[NP];
  logic          force_p1;

  assign req      = {p1_req, p0_req};
  assign we       = {p1_we, p0_we};
  assign addr[0]  = p0_addr;
  assign addr[1]  = p1_addr;
  assign wdata[0] = p0_wdata;
  assign wdata[1] = p1_wdata;

`ifdef MEM_ARB_STARVE_LIMIT_EN
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;

  assign force_p1 = (wait_cnt_reg == WAIT_LIM);

  // Counts consecutive cycles port 1 has been left waiting; any grant or withdrawal restarts it.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!p1_req || gnt[1]) begin
      wait_cnt_next = 4'd0;
    end else if (wait_cnt_reg < WAIT_LIM) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      wait_cnt_reg <= 4'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`else
  assign force_p1 = 1'b0;
`endif

  // Grants are gated by reset so the memory sees no strobe while reset is asserted.
  assign gnt[1] = !rst_async && req[1] && (!req[0] || force_p1);
  assign gnt[0] = !rst_async && req[0] && !gnt[1];

  always_comb begin
    mem_address     = 20'd0;
    mem_write_en    = 1'b0;
    mem_write_value = 32'd0;
    if (gnt[0]) begin
      mem_address     = addr[0];
      mem_write_en    = we[0];
      mem_write_value = wdata[0];
    end else if (gnt[1]) begin
      mem_address     = addr[1];
      mem_write_en    = we[1];
      mem_write_value = wdata[1];
    end
  end

  // Read data is sampled from the shared memory on the granting edge and held until the next read.
  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
        rvalid_reg[gi] <= 1'b0;
        rdata_reg[gi]  <= 32'd0;
      end else begin
        rvalid_reg[gi] <= gnt[gi] && !we[gi];
        if (gnt[gi] && !we[gi]) begin
          rdata_reg[gi] <= mem_read_value;
        end
      end
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid_reg[0];
  assign p1_rvalid = rvalid_reg[1];
  assign p0_rdata  = rdata_reg[0];
  assign p1_rdata  = rdata_reg[1];

endmodule
